// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/HALT sequencing, trap and redirect handling,
// misaligned-target detection and a small circular return-address stack.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter bit              C_EXT        = 1'b0,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap,
    input  logic            halt,
    input  logic            resume,
    input  logic            ras_push,
    input  logic            ras_pop,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fetch_valid,
    output logic            misalign,
    output logic [XLEN-1:0] bad_addr,
    output logic            ras_empty,
    output logic            ras_full
);
    localparam int PW = $clog2(RAS_DEPTH);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t          state;
    logic [XLEN-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]   ptr;      // next free slot; top of stack is ptr-1
    logic [PW:0]     count;
    logic [PW-1:0]   top_idx;
    logic [PW-1:0]   widx;
    logic            misaligned_tgt;
    logic            advance;
    logic            push_ok;
    logic            pop_ok;

    assign pc_plus4  = pc + XLEN'(4);
    assign top_idx   = ptr - PW'(1);
    assign ras_empty = (count == '0);
    assign ras_full  = (count == (PW+1)'(RAS_DEPTH));

    assign misaligned_tgt = C_EXT ? redirect_pc[0] : (redirect_pc[1:0] != 2'b00);

    // RAS only moves when the PC takes its sequential/return path
    assign advance = (state == RUN) && !trap && !redirect && !halt && !stall;
    assign pop_ok  = advance && ras_pop && !ras_empty;
    assign push_ok = advance && ras_push;
    // simultaneous push+pop replaces the top in place
    assign widx    = pop_ok ? top_idx : ptr;

    always_ff @(posedge clk) begin
        if (!rst && push_ok)
            ras[widx] <= pc_plus4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_VECTOR;
            fetch_valid <= 1'b0;
            misalign    <= 1'b0;
            bad_addr    <= '0;
            count       <= '0;
            ptr         <= '0;
        end else begin
            misalign <= 1'b0;
            case (state)
                BOOT: begin
                    state       <= RUN;
                    fetch_valid <= 1'b1;
                end
                RUN: begin
                    if (trap) begin
                        pc    <= TRAP_VECTOR;
                        count <= '0;
                    end else if (redirect && misaligned_tgt) begin
                        pc       <= TRAP_VECTOR;
                        misalign <= 1'b1;
                        bad_addr <= redirect_pc;
                        count    <= '0;
                    end else if (redirect) begin
                        pc <= redirect_pc;
                    end else if (halt) begin
                        state       <= HALT;
                        fetch_valid <= 1'b0;
                    end else if (!stall) begin
                        pc <= pop_ok ? ras[top_idx] : pc_plus4;
                        if (push_ok && !pop_ok) begin
                            ptr <= ptr + PW'(1);
                            if (!ras_full)
                                count <= count + (PW+1)'(1);
                        end else if (pop_ok && !push_ok) begin
                            ptr   <= top_idx;
                            count <= count - (PW+1)'(1);
                        end
                    end
                end
                HALT: begin
                    if (trap) begin
                        pc          <= TRAP_VECTOR;
                        count       <= '0;
                        state       <= RUN;
                        fetch_valid <= 1'b1;
                    end else if (resume) begin
                        state       <= RUN;
                        fetch_valid <= 1'b1;
                    end
                end
                default: begin
                    state       <= BOOT;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: two instances (C_EXT=0 and C_EXT=1) share stimulus; an
// ordered-list model is compared every cycle, plus literal spot checks.
module tb_pc_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 0, redirect = 0, trap = 0, halt = 0, resume = 0;
    logic        ras_push = 0, ras_pop = 0;
    logic [31:0] redirect_pc = '0;

    logic [31:0] pc [2];
    logic [31:0] pc_plus4 [2];
    logic [31:0] bad_addr [2];
    logic        fetch_valid [2];
    logic        misalign [2];
    logic        ras_empty [2];
    logic        ras_full [2];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pc_gen #(.C_EXT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .trap(trap), .halt(halt), .resume(resume), .ras_push(ras_push), .ras_pop(ras_pop),
        .pc(pc[0]), .pc_plus4(pc_plus4[0]), .fetch_valid(fetch_valid[0]), .misalign(misalign[0]),
        .bad_addr(bad_addr[0]), .ras_empty(ras_empty[0]), .ras_full(ras_full[0]));

    pc_gen #(.C_EXT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .trap(trap), .halt(halt), .resume(resume), .ras_push(ras_push), .ras_pop(ras_pop),
        .pc(pc[1]), .pc_plus4(pc_plus4[1]), .fetch_valid(fetch_valid[1]), .misalign(misalign[1]),
        .bad_addr(bad_addr[1]), .ras_empty(ras_empty[1]), .ras_full(ras_full[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0=boot 1=run 2=halt; RAS as an ordered list, newest last.
    int          mmode [2];
    logic [31:0] mpc [2];
    logic [31:0] mbad [2];
    logic        mmis [2];
    logic [31:0] mras [2][4];
    int          msz [2];
    bit          started = 0;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic        odd;
            logic [31:0] nxt, newpc;
            odd = (k == 1) ? redirect_pc[0] : (redirect_pc[1:0] != 2'b00);
            mmis[k] = 1'b0;
            if (rst) begin
                mmode[k] = 0; mpc[k] = 32'h0; mbad[k] = 32'h0; msz[k] = 0;
            end else if (mmode[k] == 0) begin
                mmode[k] = 1;
            end else if (mmode[k] == 2) begin
                if (trap) begin
                    mpc[k] = 32'h100; msz[k] = 0; mmode[k] = 1;
                end else if (resume) begin
                    mmode[k] = 1;
                end
            end else if (trap) begin
                mpc[k] = 32'h100; msz[k] = 0;
            end else if (redirect && odd) begin
                mpc[k] = 32'h100; mmis[k] = 1'b1; mbad[k] = redirect_pc; msz[k] = 0;
            end else if (redirect) begin
                mpc[k] = redirect_pc;
            end else if (halt) begin
                mmode[k] = 2;
            end else if (!stall) begin
                nxt = mpc[k] + 32'd4;
                newpc = nxt;
                if (ras_pop && msz[k] > 0) begin
                    newpc = mras[k][msz[k]-1];
                    msz[k]--;
                end
                if (ras_push) begin
                    if (msz[k] == 4) begin
                        for (int j = 0; j < 3; j++) mras[k][j] = mras[k][j+1];
                        msz[k] = 3;
                    end
                    mras[k][msz[k]] = nxt;
                    msz[k]++;
                end
                mpc[k] = newpc;
            end
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("u%0d.pc", k), pc[k], mpc[k]);
                chk($sformatf("u%0d.pc_plus4", k), pc_plus4[k], mpc[k] + 32'd4);
                chk($sformatf("u%0d.fetch_valid", k), 32'(fetch_valid[k]), 32'(mmode[k] == 1));
                chk($sformatf("u%0d.misalign", k), 32'(misalign[k]), 32'(mmis[k]));
                chk($sformatf("u%0d.bad_addr", k), bad_addr[k], mbad[k]);
                chk($sformatf("u%0d.ras_empty", k), 32'(ras_empty[k]), 32'(msz[k] == 0));
                chk($sformatf("u%0d.ras_full", k), 32'(ras_full[k]), 32'(msz[k] == 4));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        stall = 0; redirect = 0; redirect_pc = '0; trap = 0; halt = 0; resume = 0;
        ras_push = 0; ras_pop = 0;
    endtask

    task automatic jump(input logic [31:0] a);
        redirect = 1; redirect_pc = a; tick();
    endtask

    initial begin
        // reset and boot
        tick(); tick();
        rst = 0;
        chk("rst.pc", pc[0], 32'h0);
        chk("rst.fv", 32'(fetch_valid[0]), 0);
        chk("rst.empty", 32'(ras_empty[0]), 1);
        tick();
        chk("boot.pc", pc[0], 32'h0);
        chk("boot.fv", 32'(fetch_valid[0]), 1);
        tick(); chk("seq.pc4", pc[0], 32'h4);
        tick(); chk("seq.pc8", pc[0], 32'h8);
        tick(); tick(); chk("seq.pc10", pc[0], 32'h10);

        // priority
        trap = 1; redirect = 1; redirect_pc = 32'h40; stall = 1; tick();
        chk("prio.trap", pc[0], 32'h100);
        redirect = 1; redirect_pc = 32'h40; stall = 1; tick();
        chk("prio.redir", pc[0], 32'h40);

        // misalign: only C_EXT=0 traps on 0x42
        jump(32'h42);
        chk("mis.pc0", pc[0], 32'h100);
        chk("mis.pulse0", 32'(misalign[0]), 1);
        chk("mis.bad0", bad_addr[0], 32'h42);
        chk("mis.pc1", pc[1], 32'h42);
        chk("mis.pulse1", 32'(misalign[1]), 0);
        tick();
        chk("mis.clear0", 32'(misalign[0]), 0);
        jump(32'h41);
        chk("mis.odd1", pc[1], 32'h100);
        chk("mis.bad1", bad_addr[1], 32'h41);

        // RAS call/return
        jump(32'h20);
        ras_push = 1; tick(); chk("ras.push1", pc[0], 32'h24);
        jump(32'h80);
        ras_push = 1; tick(); chk("ras.push2", pc[0], 32'h84);
        ras_pop = 1; tick(); chk("ras.pop1", pc[0], 32'h84);
        ras_pop = 1; tick(); chk("ras.pop2", pc[0], 32'h24);
        chk("ras.empty", 32'(ras_empty[0]), 1);
        ras_pop = 1; tick(); chk("ras.pop3", pc[0], 32'h28);

        // overflow: five pushes keep the four newest
        jump(32'h1000);
        for (int i = 0; i < 5; i++) begin ras_push = 1; tick(); end
        chk("ovf.full", 32'(ras_full[0]), 1);
        chk("ovf.pc", pc[0], 32'h1014);
        ras_pop = 1; tick(); chk("ovf.pop1", pc[0], 32'h1014);
        ras_pop = 1; tick(); chk("ovf.pop2", pc[0], 32'h1010);
        ras_pop = 1; tick(); chk("ovf.pop3", pc[0], 32'h100C);
        ras_pop = 1; tick(); chk("ovf.pop4", pc[0], 32'h1008);
        chk("ovf.empty", 32'(ras_empty[0]), 1);
        ras_pop = 1; tick(); chk("ovf.pop5", pc[0], 32'h100C);

        // simultaneous push+pop
        jump(32'h1FC);
        ras_push = 1; tick(); chk("pp.setup", pc[0], 32'h200);
        jump(32'h30);
        ras_push = 1; ras_pop = 1; tick();
        chk("pp.pc", pc[0], 32'h200);
        chk("pp.notempty", 32'(ras_empty[0]), 0);
        ras_pop = 1; tick(); chk("pp.newtop", pc[0], 32'h34);
        chk("pp.empty", 32'(ras_empty[0]), 1);

        // halt / resume
        jump(32'h50);
        halt = 1; tick();
        chk("halt.pc", pc[0], 32'h50);
        chk("halt.fv", 32'(fetch_valid[0]), 0);
        redirect = 1; redirect_pc = 32'h80; stall = 1; ras_push = 1; tick();
        chk("halt.ign", pc[0], 32'h50);
        resume = 1; tick();
        chk("resume.pc", pc[0], 32'h50);
        chk("resume.fv", 32'(fetch_valid[0]), 1);
        tick(); chk("resume.step", pc[0], 32'h54);
        halt = 1; tick();
        trap = 1; tick();
        chk("halt.trap", pc[0], 32'h100);
        chk("halt.trapfv", 32'(fetch_valid[0]), 1);

        // wrap
        jump(32'hFFFF_FFFC);
        chk("wrap.p4", pc_plus4[0], 32'h0);
        tick(); chk("wrap.pc", pc[0], 32'h0);

        // reset mid-operation while halted with RAS contents
        ras_push = 1; tick(); ras_push = 1; tick();
        halt = 1; tick();
        rst = 1; tick(); rst = 0;
        chk("mrst.pc", pc[0], 32'h0);
        chk("mrst.empty", 32'(ras_empty[0]), 1);
        chk("mrst.fv", 32'(fetch_valid[0]), 0);
        tick(); tick();
        chk("mrst.run", pc[0], 32'h4);

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the RISC-V core.
- Supersedes the two-way new/sequential PC register. Adds:
  - configurable width and vectors;
  - stall, trap and halt handling;
  - misaligned-target detection;
  - a small return-address stack (RAS) for call/return prediction.
- Sits between the control/branch unit and instruction memory. Drives the fetch address and a fetch-valid qualifier.

Parameters:
- XLEN, 32, PC/address width (≥ 16).
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or misaligned redirect.
- C_EXT, 0, 1 = 16-bit alignment legal (check bit 0 only); 0 = check bits [1:0].
- RAS_DEPTH, 4, RAS entries (power of two, ≥ 2).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold PC this cycle
- redirect  in  1  branch/jump taken
- redirect_pc  in  XLEN  branch/jump target
- trap  in  1  exception/interrupt entry
- halt  in  1  request halt (debug/WFI)
- resume  in  1  leave halt
- ras_push  in  1  call: push pc+4
- ras_pop  in  1  return: next PC from RAS top
- pc  out  XLEN  current fetch address (registered)
- pc_plus4  out  XLEN  combinational pc+4, wraps modulo 2^XLEN
- fetch_valid  out  1  pc is a valid fetch address
- misalign  out  1  one-cycle pulse on misaligned redirect
- bad_addr  out  XLEN  last misaligned target (registered)
- ras_empty  out  1  RAS count == 0
- ras_full  out  1  RAS count == RAS_DEPTH

Behaviour:
- Reset is synchronous, active-high, clock clk. On rst:
  - pc=RESET_VECTOR, state=BOOT, fetch_valid=0, misalign=0, bad_addr=0;
  - RAS count=0, pointer=0 (ras_empty=1, ras_full=0).
- rst overrides all other inputs. Reset mid-operation discards RAS contents and any halt.

State machine: BOOT, RUN, HALT. fetch_valid=1 only in RUN.

BOOT:
- Exactly one cycle; then RUN.
- pc holds RESET_VECTOR; all other inputs are ignored.

RUN, next-PC priority (highest first):
1. trap: pc<=TRAP_VECTOR; RAS flushed (count=0).
2. redirect with misaligned target: pc<=TRAP_VECTOR, misalign pulses next cycle, bad_addr<=redirect_pc, RAS flushed.
   - Misaligned means redirect_pc[0]!=0 when C_EXT=1, or redirect_pc[1:0]!=0 when C_EXT=0.
3. redirect, aligned: pc<=redirect_pc; RAS untouched.
4. halt: pc holds; state<=HALT.
5. stall: pc holds; push/pop ignored.
6. ras_pop with RAS not empty: pc<=RAS top; count decrements.
7. Otherwise: pc<=pc_plus4.

RAS rules:
- ras_push and ras_pop act only in cases 6/7 (PC advancing, not trapped/redirected/stalled/halting).
- ras_push writes pc_plus4 at the top.
- Push when full: circular overwrite of the oldest entry; count saturates at RAS_DEPTH; pointer wraps modulo RAS_DEPTH.
- Pop when empty: treated as no pop; pc<=pc_plus4; no error.
- Push and pop in the same cycle: pc<=old top, then top entry<=pc_plus4; count unchanged.

HALT:
- pc holds; fetch_valid=0.
- trap: pc<=TRAP_VECTOR, RAS flushed, state<=RUN.
- Else resume: state<=RUN with pc unchanged.
- redirect, stall and RAS inputs are ignored.

Other rules:
- misalign is high for exactly one cycle per misaligned redirect; otherwise 0.
- bad_addr changes only on a misaligned redirect.
- Latency: every PC decision is visible on pc one cycle after the inputs are sampled.

Test Plan:
- Reset/boot: assert rst 2 cycles, release → pc=0, fetch_valid=0 for 1 cycle, then pc 0→4→8 with fetch_valid=1.
- Priority: at pc=0x10, assert trap+redirect(0x40)+stall → pc=0x100. Next cycle redirect=0x40 with stall → pc=0x40.
- Misalign (C_EXT=0): redirect_pc=0x42 → pc=0x100, misalign=1 for one cycle, bad_addr=0x42. With C_EXT=1 the same target → pc=0x42, no pulse.
- RAS: push at pc=0x20 and 0x80, then pop twice → pc=0x84, then 0x24, ras_empty=1. A third pop → pc=prev+4.
- RAS overflow/simultaneous (RAS_DEPTH=4): 5 pushes → ras_full=1, pops return the 4 newest entries only. Push+pop together at pc=0x30 with top=0x200 → pc=0x200, top becomes 0x34, count unchanged.
- Halt and wrap: halt at pc=0x50 → pc holds 0x50, fetch_valid=0 until resume, then 0x54. With pc=0xFFFF_FFFC, sequential step → pc=0x0.
